// File: rtl/mux_scan_nw_pkg.sv
// mux_scan_pkg: shared state encoding and a width helper for the scanning mux.
// Optional feature macro used by this block: CHAN_MASK_EN.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bits needed to index v distinct values (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_nw_if.sv
// mux_scan_nw_if: request, data and output-handshake signals of the scanning mux.
// chan_mask exists only when CHAN_MASK_EN is defined.
interface mux_scan_nw_if import mux_scan_pkg::*; #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SELW = clog2(N);

    logic            mode;
    logic [SELW-1:0] sel;
    logic            start;
    logic [N*W-1:0]  d;
    logic            out_ready;
    logic            out_valid;
    logic [W-1:0]    y;
    logic [SELW-1:0] y_chan;
    logic            busy;
    logic            err;
`ifdef CHAN_MASK_EN
    logic [N-1:0]    chan_mask;
`endif

    // Driver side: sources, operator and consumer.
    modport master (
`ifdef CHAN_MASK_EN
        output chan_mask,
`endif
        output mode, sel, start, d, out_ready,
        input  out_valid, y, y_chan, busy, err
    );

    // Mux side.
    modport slave (
`ifdef CHAN_MASK_EN
        input  chan_mask,
`endif
        input  mode, sel, start, d, out_ready,
        output out_valid, y, y_chan, busy, err
    );

endinterface

// File: rtl/mux_scan_nw_mux.sv
// mux_nw: combinational N:1 selector of W-bit channels; out-of-range index yields 0.
module mux_nw import mux_scan_pkg::*; #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SELW = clog2(N)
) (
    input  logic [N*W-1:0]  d,
    input  logic [SELW-1:0] idx,
    output logic [W-1:0]    q
);

    // Only an exact in-range match drives q, so idx >= N falls through to 0.
    always_comb begin
        q = '0;
        for (int k = 0; k < N; k++)
            if (idx == SELW'(k)) q = d[k*W +: W];
    end

endmodule

// File: rtl/mux_scan_nw.sv
// mux_scan_nw: registered N-channel mux with manual capture and auto sweep,
// dwell delay before each auto sample, and valid/ready output.
// Define CHAN_MASK_EN to add per-channel enables (bus.chan_mask).
module mux_scan_nw import mux_scan_pkg::*; #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 2
) (
    input logic          clk,
    input logic          rst,
    mux_scan_nw_if.slave bus
);

    localparam int SELW = clog2(N);
    localparam int CW   = clog2(DWELL + 1);

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [CW-1:0]   cnt;
    logic            auto_m;
    logic            out_valid_r, busy_r, err_r;
    logic [W-1:0]    y_r;
    logic [SELW-1:0] y_chan_r;

    logic [N-1:0]    mask;
    logic [SELW-1:0] idx;
    logic [W-1:0]    q;
    logic            first_ok, next_ok, sel_ok;
    logic [SELW-1:0] first_idx, next_idx;

`ifdef CHAN_MASK_EN
    assign mask = bus.chan_mask;
`else
    assign mask = '1;
`endif

    // In IDLE the selector looks at the operator's sel, otherwise at the sweep pointer.
    assign idx = (state == IDLE) ? bus.sel : ptr;

    mux_nw #(.N(N), .W(W)) u_mux (.d(bus.d), .idx(idx), .q(q));

    // Enabled-channel search: lowest enabled, lowest enabled above ptr, and sel validity.
    always_comb begin
        first_ok  = 1'b0;
        first_idx = '0;
        next_ok   = 1'b0;
        next_idx  = '0;
        sel_ok    = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k]) begin
                first_ok  = 1'b1;
                first_idx = SELW'(k);
            end
            if (mask[k] && (SELW'(k) > ptr)) begin
                next_ok  = 1'b1;
                next_idx = SELW'(k);
            end
            if (mask[k] && (SELW'(k) == bus.sel)) sel_ok = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs; skipped channels cost no dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            auto_m      <= 1'b0;
            out_valid_r <= 1'b0;
            y_r         <= '0;
            y_chan_r    <= '0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (!bus.mode) begin
                            if (sel_ok) begin
                                state       <= HOLD;
                                auto_m      <= 1'b0;
                                out_valid_r <= 1'b1;
                                y_r         <= q;
                                y_chan_r    <= bus.sel;
                                busy_r      <= 1'b1;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end else if (first_ok) begin
                            state  <= SCAN;
                            auto_m <= 1'b1;
                            ptr    <= first_idx;
                            cnt    <= '0;
                            busy_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DWELL - 1)) begin
                        state       <= HOLD;
                        y_r         <= q;
                        y_chan_r    <= ptr;
                        out_valid_r <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (auto_m && next_ok) begin
                            state <= SCAN;
                            ptr   <= next_idx;
                            cnt   <= '0;
                        end else begin
                            state  <= IDLE;
                            ptr    <= '0;
                            busy_r <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.y_chan    = y_chan_r;
    assign bus.busy      = busy_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_mux_scan_nw.sv
// tb_mux_scan_nw: randomized self-checking bench for mux_scan_nw (N=4, W=8, DWELL=2)
// plus an N=3 instance for the out-of-range select case. Honors CHAN_MASK_EN.
module tb_mux_scan_nw;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DWELL = 2;
    localparam int SELW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   pass  = 0;

    always #5 clk = ~clk;

    mux_scan_nw_if #(.N(N), .W(W)) bus ();
    mux_scan_nw_if #(.N(3), .W(W)) bus3 ();

    mux_scan_nw #(.N(N), .W(W), .DWELL(DWELL)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    mux_scan_nw #(.N(3), .W(W), .DWELL(DWELL)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rand_d();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        logic [N*W-1:0] dv;
        rst = 1'b1;
        step(); step();
        total++;
        if ({bus.out_valid, bus.busy, bus.err, bus.y, bus.y_chan} !== '0)
            $display("FAIL reset_por: got v=%b b=%b e=%b y=%h ch=%0d exp all 0",
                     bus.out_valid, bus.busy, bus.err, bus.y, bus.y_chan);
        else pass++;
        rst = 1'b0;
        // Leave a nonzero sample behind, then reset in the middle of a sweep.
        dv = 32'h44332211;
        bus.d = dv; bus.mode = 1'b0; bus.sel = 2'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0; bus.mode = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step(); step();
        total++;
        if ({bus.out_valid, bus.busy, bus.err, bus.y, bus.y_chan} !== '0)
            $display("FAIL reset_midscan: got v=%b b=%b e=%b y=%h ch=%0d exp all 0",
                     bus.out_valid, bus.busy, bus.err, bus.y, bus.y_chan);
        else pass++;
        rst = 1'b0;
        step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset_nopending: got v=%b b=%b exp 0 0", bus.out_valid, bus.busy);
        else pass++;
        dv = rand_d();
        bus.d = dv; bus.mode = 1'b0; bus.sel = 2'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.y !== dv[W +: W] || bus.y_chan !== 2'd1)
            $display("FAIL reset_after_start: got v=%b y=%h ch=%0d exp 1 %h 1",
                     bus.out_valid, bus.y, bus.y_chan, dv[W +: W]);
        else pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
    endtask

    task automatic test_manual(input logic [N*W-1:0] dv, input int s);
        logic [W-1:0] ey;
        ey = dv[s*W +: W];
        bus.d = dv; bus.mode = 1'b0; bus.sel = SELW'(s); bus.start = 1'b1; bus.out_ready = 1'b0;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.y !== ey || bus.y_chan !== SELW'(s) || bus.busy !== 1'b1)
            $display("FAIL manual_sample: got v=%b y=%h ch=%0d b=%b exp 1 %h %0d 1",
                     bus.out_valid, bus.y, bus.y_chan, bus.busy, ey, s);
        else pass++;
        for (int i = 0; i < 5; i++) begin
            bus.d = rand_d();
            step();
            total++;
            if (bus.out_valid !== 1'b1 || bus.y !== ey || bus.y_chan !== SELW'(s))
                $display("FAIL manual_hold%0d: got v=%b y=%h ch=%0d exp 1 %h %0d",
                         i, bus.out_valid, bus.y, bus.y_chan, ey, s);
            else pass++;
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL manual_accept: got v=%b b=%b exp 0 0", bus.out_valid, bus.busy);
        else pass++;
        step();
    endtask

    task automatic test_auto(input bit rnd_ready, input bit poke_start);
        logic [N-1:0]   m;
        int             chans[$];
        logic [N*W-1:0] dv;
        logic [W-1:0]   ey;
        bit             acc;
        int             hc;
        m = '1;
`ifdef CHAN_MASK_EN
        do m = N'($urandom); while (m == '0);
        bus.chan_mask = m;
`endif
        for (int k = 0; k < N; k++) if (m[k]) chans.push_back(k);
        bus.mode = 1'b1; bus.sel = SELW'($urandom); bus.start = 1'b1; bus.out_ready = 1'b0;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL auto_start: got b=%b v=%b e=%b exp 1 0 0", bus.busy, bus.out_valid, bus.err);
        else pass++;
        foreach (chans[j]) begin
            // DWELL edges after entering SCAN the channel is captured.
            for (int i = 1; i <= DWELL; i++) begin
                dv = rand_d();
                bus.d = dv;
                bus.out_ready = rnd_ready ? 1'($urandom) : 1'b1;
                bus.start = poke_start ? 1'($urandom) : 1'b0;
                step();
                if (i < DWELL) begin
                    total++;
                    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.err !== 1'b0)
                        $display("FAIL auto_dwell ch%0d: got v=%b b=%b e=%b exp 0 1 0",
                                 chans[j], bus.out_valid, bus.busy, bus.err);
                    else pass++;
                end
            end
            ey = dv[chans[j]*W +: W];
            total++;
            if (bus.out_valid !== 1'b1 || bus.y !== ey || bus.y_chan !== SELW'(chans[j]) || bus.err !== 1'b0)
                $display("FAIL auto_sample ch%0d: got v=%b y=%h ch=%0d e=%b exp 1 %h %0d 0",
                         chans[j], bus.out_valid, bus.y, bus.y_chan, bus.err, ey, chans[j]);
            else pass++;
            acc = 1'b0;
            hc  = 0;
            while (!acc) begin
                bus.d = rand_d();
                bus.start = poke_start ? 1'($urandom) : 1'b0;
                acc = !rnd_ready || hc >= 6 || $urandom_range(0, 2) == 0;
                bus.out_ready = acc;
                step();
                hc++;
                if (!acc) begin
                    total++;
                    if (bus.out_valid !== 1'b1 || bus.y !== ey || bus.y_chan !== SELW'(chans[j]) || bus.err !== 1'b0)
                        $display("FAIL auto_hold ch%0d: got v=%b y=%h ch=%0d e=%b exp 1 %h %0d 0",
                                 chans[j], bus.out_valid, bus.y, bus.y_chan, bus.err, ey, chans[j]);
                    else pass++;
                end
            end
            total++;
            if (bus.out_valid !== 1'b0 || bus.busy !== (j < chans.size() - 1) || bus.err !== 1'b0)
                $display("FAIL auto_accept ch%0d: got v=%b b=%b e=%b exp 0 %b 0",
                         chans[j], bus.out_valid, bus.busy, bus.err, (j < chans.size() - 1));
            else pass++;
        end
        bus.start = 1'b0; bus.out_ready = 1'b0;
`ifdef CHAN_MASK_EN
        bus.chan_mask = '1;
`endif
        step();
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] dv;
        dv = rand_d();
        bus.d = dv; bus.mode = 1'b0; bus.sel = 2'd0; bus.start = 1'b1; bus.out_ready = 1'b0;
        step();
        // Accept and re-request on the same edge: the request lands while still in HOLD.
        bus.sel = 2'd1; bus.out_ready = 1'b1;
        step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL b2b_gap: got v=%b b=%b e=%b exp 0 0 0", bus.out_valid, bus.busy, bus.err);
        else pass++;
        bus.out_ready = 1'b0;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.y !== dv[W +: W] || bus.y_chan !== 2'd1)
            $display("FAIL b2b_second: got v=%b y=%h ch=%0d exp 1 %h 1",
                     bus.out_valid, bus.y, bus.y_chan, dv[W +: W]);
        else pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
    endtask

    task automatic test_bad_sel();
        bus3.d = 24'hCCBBAA; bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.start = 1'b1; bus3.out_ready = 1'b0;
        step();
        bus3.start = 1'b0;
        total++;
        if (bus3.err !== 1'b1 || bus3.out_valid !== 1'b0 || bus3.busy !== 1'b0)
            $display("FAIL badsel_pulse: got e=%b v=%b b=%b exp 1 0 0", bus3.err, bus3.out_valid, bus3.busy);
        else pass++;
        step();
        total++;
        if (bus3.err !== 1'b0 || bus3.out_valid !== 1'b0)
            $display("FAIL badsel_after: got e=%b v=%b exp 0 0", bus3.err, bus3.out_valid);
        else pass++;
        bus3.sel = 2'd2; bus3.start = 1'b1;
        step();
        bus3.start = 1'b0;
        total++;
        if (bus3.out_valid !== 1'b1 || bus3.y !== 8'hCC || bus3.err !== 1'b0)
            $display("FAIL badsel_valid: got v=%b y=%h e=%b exp 1 cc 0", bus3.out_valid, bus3.y, bus3.err);
        else pass++;
        bus3.out_ready = 1'b1;
        step();
        bus3.out_ready = 1'b0;
    endtask

`ifdef CHAN_MASK_EN
    task automatic test_mask();
        bus.chan_mask = 4'b0000; bus.mode = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL mask_zero: got e=%b b=%b exp 1 0", bus.err, bus.busy);
        else pass++;
        step();
        bus.chan_mask = 4'b1010; bus.mode = 1'b0; bus.sel = 2'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.err !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL mask_manual: got e=%b v=%b exp 1 0", bus.err, bus.out_valid);
        else pass++;
        bus.chan_mask = '1;
        step();
    endtask
`endif

    initial begin
        bus.mode = 1'b0; bus.sel = '0; bus.start = 1'b0; bus.d = '0; bus.out_ready = 1'b0;
        bus3.mode = 1'b0; bus3.sel = '0; bus3.start = 1'b0; bus3.d = '0; bus3.out_ready = 1'b0;
`ifdef CHAN_MASK_EN
        bus.chan_mask = '1;
        bus3.chan_mask = '1;
`endif
        test_reset();
        test_manual(32'h44332211, 2);
        for (int r = 0; r < 3; r++) test_manual(rand_d(), $urandom_range(0, N - 1));
        test_auto(1'b0, 1'b0);
        for (int r = 0; r < 6; r++) test_auto(1'b1, 1'b1);
        test_back_to_back();
        test_bad_sel();
`ifdef CHAN_MASK_EN
        test_mask();
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
